// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: clear-sweep FSM encoding and default geometry.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: walks every entry once, zeroing one address per cycle.
// Reset lands in the sweep, so storage is scrubbed after every reset release.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              busy_nxt,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_stb
);

    // One extra bit keeps the counter from wrapping before the last entry is cleared.
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    clr_state_e        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // Next-state and sweep-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset restarts the sweep at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign busy_nxt = (state_d == ST_CLEAR);
    assign clr_stb  = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with byte enables, registered reads and a clear sweep.
// Define REGISTER_FILE_BYPASS_EN for write-first reads; default is read-first.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic                clr_req,
    output logic                busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic [DATA_W-1:0] merged_d;
    logic              wr_commit_d;
    logic              busy_s, busy_nxt_s, clr_stb_s;
    logic [ADDR_W-1:0] clr_addr_s;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy_s),
        .busy_nxt (busy_nxt_s),
        .clr_addr (clr_addr_s),
        .clr_stb  (clr_stb_s)
    );

    // Write qualification and byte merge of new data over the stored word.
    always_comb begin
        wr_commit_d = wr_en && !busy_s && !((ZERO_REG != 0) && (wr_addr == '0));
        merged_d    = mem_q[wr_addr];
        for (int b = 0; b < NB; b++) begin
            merged_d[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : mem_q[wr_addr][8*b +: 8];
        end
    end

    // Read data is forced to zero on either side of a busy edge so it never shows mid-sweep state.
    always_comb begin
        rd_data_a_d = mem_q[rd_addr_a];
        rd_data_b_d = mem_q[rd_addr_b];
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_commit_d && (rd_addr_a == wr_addr)) begin
            rd_data_a_d = merged_d;
        end else begin
            rd_data_a_d = mem_q[rd_addr_a];
        end
        if (wr_commit_d && (rd_addr_b == wr_addr)) begin
            rd_data_b_d = merged_d;
        end else begin
            rd_data_b_d = mem_q[rd_addr_b];
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
            rd_data_a_d = '0;
        end else begin
            rd_data_a_d = rd_data_a_d;
        end
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
            rd_data_b_d = '0;
        end else begin
            rd_data_b_d = rd_data_b_d;
        end
        if (busy_s || busy_nxt_s) begin
            rd_data_a_d = '0;
            rd_data_b_d = '0;
        end else begin
            rd_data_b_d = rd_data_b_d;
        end
    end

    // Storage array: sweep clears take the port exclusively, otherwise qualified writes land.
    always_ff @(posedge clk) begin
        if (clr_stb_s) begin
            mem_q[clr_addr_s] <= '0;
        end else if (wr_commit_d) begin
            mem_q[wr_addr] <= merged_d;
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign busy      = busy_s;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (DATA_W=32, ADDR_W=5, ZERO_REG=1).
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'h0;
    logic [3:0]  wr_be = 4'h0;
    logic [4:0]  rd_addr_a = 5'd0;
    logic [4:0]  rd_addr_b = 5'd0;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        clr_req = 1'b0;
    logic        busy;

    int passed = 0;
    int total  = 0;
    int n;

    register_file #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int cycles = 1);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0; wr_be = 4'h0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        rd_addr_a = a; rd_addr_b = b;
        step();
    endtask

    initial begin
        #2 rst = 1'b1;
        step(3);
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_rd_a", rd_data_a, 32'h0);
        check("reset_rd_b", rd_data_b, 32'h0);

        rst = 1'b0;
        count_busy(n);
        check("init_sweep_len", n, 32'd32);

        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            check("init_zero_a", rd_data_a, 32'h0);
            check("init_zero_b", rd_data_b, 32'h0);
        end

        wr(5'd4, 32'hACEDCAFE, 4'b1111);
        wr(5'd4, 32'hDEADBEEF, 4'b0011);
        rd(5'd4, 5'd4);
        check("byte_merge_a", rd_data_a, 32'hACEDBEEF);
        check("byte_merge_b", rd_data_b, 32'hACEDBEEF);

        wr(5'd4, 32'h00000000, 4'b0000);
        rd(5'd4, 5'd1);
        check("be_zero_hold", rd_data_a, 32'hACEDBEEF);

        wr(5'd4, 32'h55000000, 4'b1000);
        rd(5'd4, 5'd4);
        check("top_byte", rd_data_b, 32'h55EDBEEF);

        wr(5'd0, 32'h12345678, 4'b1111);
        rd(5'd0, 5'd0);
        check("zero_reg_a", rd_data_a, 32'h0);
        check("zero_reg_b", rd_data_b, 32'h0);

        wr(5'd9, 32'hCAFEF00D, 4'b1111);
        rd(5'd4, 5'd9);
        check("indep_a", rd_data_a, 32'h55EDBEEF);
        check("indep_b", rd_data_b, 32'hCAFEF00D);

        wr(5'd7, 32'h22222222, 4'b1111);
        rd_addr_a = 5'd7;
        wr(5'd7, 32'h11111111, 4'b1111);
`ifdef REGISTER_FILE_BYPASS_EN
        check("same_cycle_rd", rd_data_a, 32'h11111111);
`else
        check("same_cycle_rd", rd_data_a, 32'h22222222);
`endif
        rd(5'd7, 5'd7);
        check("after_write_rd", rd_data_a, 32'h11111111);

        // Sweep with a write at cycle 10 and a repeated clr_req at cycle 12.
        rd_addr_a = 5'd7; rd_addr_b = 5'd9;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("sweep_rd_a_zero", rd_data_a, 32'h0);
        check("sweep_rd_b_zero", rd_data_b, 32'h0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            wr_en   = (n == 10);
            wr_addr = 5'd3;
            wr_data = 32'hFFFFFFFF;
            wr_be   = 4'hF;
            clr_req = (n == 12);
            step();
        end
        wr_en = 1'b0; wr_be = 4'h0; clr_req = 1'b0;
        check("clr_sweep_len", n, 32'd32);
        rd(5'd3, 5'd9);
        check("dropped_write", rd_data_a, 32'h0);
        check("swept_entry", rd_data_b, 32'h0);

        // Write and clear request in the same idle cycle.
        clr_req = 1'b1;
        wr(5'd5, 32'hA5A5A5A5, 4'hF);
        clr_req = 1'b0;
        count_busy(n);
        check("wr_clr_sweep_len", n, 32'd32);
        rd(5'd5, 5'd5);
        check("wr_clr_cleared", rd_data_a, 32'h0);

        // Asynchronous reset from idle with live read data.
        wr(5'd6, 32'h600D600D, 4'hF);
        rd(5'd6, 5'd6);
        check("pre_rst_rd", rd_data_a, 32'h600D600D);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rd_a", rd_data_a, 32'h0);
        check("async_rst_rd_b", rd_data_b, 32'h0);
        check("async_rst_busy", {31'd0, busy}, 32'd1);
        step();
        rst = 1'b0;
        count_busy(n);
        check("idle_rst_sweep_len", n, 32'd32);

        // Reset in the middle of a sweep restarts it from address 0.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step(19);
        rst = 1'b1;
        #1;
        check("mid_rst_rd_a", rd_data_a, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        step();
        rst = 1'b0;
        count_busy(n);
        check("mid_rst_sweep_len", n, 32'd32);
        rd(5'd6, 5'd31);
        check("final_a", rd_data_a, 32'h0);
        check("final_b", rd_data_b, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1, entry 0 hardwired to zero when 1.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-005 SHALL have port wr_en  in  1  write request.
REQ-006 SHALL have port wr_addr  in  ADDR_W  write address.
REQ-007 SHALL have port wr_data  in  DATA_W  write data.
REQ-008 SHALL have port wr_be  in  DATA_W/8  byte enables, bit i covers wr_data[8i+7:8i].
REQ-009 SHALL have ports rd_addr_a, rd_addr_b  in  ADDR_W  read addresses.
REQ-010 SHALL have ports rd_data_a, rd_data_b  out  DATA_W  registered read data.
REQ-011 SHALL have port clr_req  in  1  single-cycle request to zero all entries.
REQ-012 SHALL have port busy  out  1  high while a clear sweep runs.

Function
REQ-013 Write: entry wr_addr SHALL update on the rising edge when wr_en=1 and busy=0; only bytes with wr_be=1 change.
REQ-014 wr_en with wr_be=0 SHALL leave storage unchanged.
REQ-015 Reads: rd_data_x SHALL hold entry rd_addr_x, sampled at the edge, valid one cycle later (latency 1); both ports independent, same address allowed.
REQ-016 ZERO_REG=1: writes to address 0 SHALL be dropped; reads of address 0 SHALL return 0.
REQ-017 FSM states IDLE, CLEAR; IDLE->CLEAR on clr_req=1; CLEAR->IDLE after the entry at address 2**ADDR_W-1 is zeroed.
REQ-018 CLEAR SHALL zero one entry per cycle, counter 0 upward, total 2**ADDR_W cycles; busy=1 throughout CLEAR.
REQ-019 While busy=1, writes SHALL be ignored (not queued) and rd_data_a/b SHALL be 0.
REQ-020 clr_req while busy=1 SHALL be ignored; the sweep SHALL not restart.
REQ-021 clr_req and wr_en in the same IDLE cycle: the write SHALL commit, then the sweep clears it.
REQ-022 Sweep counter SHALL be ADDR_W+1 bits wide or equivalent, with no wrap before completion.

Reset
REQ-023 rst=1 SHALL asynchronously force state CLEAR, sweep counter 0, busy=1, rd_data_a=0, rd_data_b=0.
REQ-024 After rst deasserts, the full sweep SHALL run before busy drops; storage SHALL not be reset asynchronously.
REQ-025 rst asserted mid-sweep SHALL restart the sweep at address 0.

Configuration
REQ-026 Macro REGISTER_FILE_BYPASS_EN defined: a read of the address being written in that cycle SHALL return the byte-merged new value (write-first).
REQ-027 Macro undefined: the same read SHALL return the pre-write value (read-first); ZERO_REG and busy rules take precedence in both cases.

Structure
REQ-028 Shared package regfile_pkg SHALL hold the FSM state encoding (ST_IDLE, ST_CLEAR) and the default DATA_W/ADDR_W constants.
REQ-029 Sweep FSM and counter SHALL be sub-module regfile_clear_fsm (outputs busy, clear address, clear strobe); storage and ports stay in register_file.

Verification (DATA_W=32, ADDR_W=5, ZERO_REG=1)
REQ-030 Release rst -> busy=1 for exactly 32 cycles, then 0; every address reads 0x00000000.
REQ-031 Write 0xACEDCAFE to addr 4, wr_be=4'b1111; next cycle write 0xDEADBEEF to addr 4, wr_be=4'b0011 -> read addr 4 gives 0xACEDBEEF one cycle after sampling.
REQ-032 Write 0x12345678 to addr 0 -> both ports read 0x00000000 from addr 0.
REQ-033 Write 0x11111111 to addr 7 while reading addr 7 on port A -> 0x11111111 with REGISTER_FILE_BYPASS_EN, previous value without.
REQ-034 Pulse clr_req, wr_en to addr 3 at sweep cycle 10, clr_req again at cycle 12 -> write dropped, busy exactly 32 cycles, addr 3 reads 0.
REQ-035 Assert rst at sweep cycle 20 -> rd_data immediately 0; after release, busy lasts 32 full cycles.
